// File: rtl/issue_age_sched.sv
// rtl/issue_age_sched.sv - age-matrix issue scheduler granting the oldest ready FU slot
module issue_age_sched #(
  parameter int NUM_FU = 5,
  parameter int IDX_W  = $clog2(NUM_FU)
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic [NUM_FU-1:0] alloc,
  input  logic [NUM_FU-1:0] rdy,
  input  logic [NUM_FU-1:0] done,
  input  logic [NUM_FU-1:0] flush,
  input  logic              freeze,
  output logic [NUM_FU-1:0] grant,
  output logic              grant_valid,
  output logic [IDX_W-1:0]  grant_idx,
  output logic [NUM_FU-1:0] busy,
  output logic [NUM_FU-1:0] in_ex
);

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_EX    = 2'd2;

  logic [NUM_FU-1:0][1:0]        state;
  logic [NUM_FU-1:0][1:0]        state_nxt;
  // older[i][j] = 1 when slot i holds an older instruction than slot j
  logic [NUM_FU-1:0][NUM_FU-1:0] older;
  logic [NUM_FU-1:0][NUM_FU-1:0] older_nxt;
  logic [NUM_FU-1:0]             new_alloc;
  logic [NUM_FU-1:0]             cand;
  logic [NUM_FU-1:0]             blocked;
  logic [NUM_FU-1:0]             unblocked;
  logic [NUM_FU-1:0]             pool;

  // Arbitration: a candidate wins when no older candidate exists; lowest index breaks any corrupt-matrix tie
  always_comb begin
    cand    = '0;
    blocked = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      cand[i] = (state[i] == ST_WAIT) && rdy[i] && !flush[i];
    end
    for (int i = 0; i < NUM_FU; i++) begin
      for (int j = 0; j < NUM_FU; j++) begin
        if (cand[j] && older[j][i]) blocked[i] = 1'b1;
      end
    end
    unblocked = cand & ~blocked;
    pool      = (unblocked != '0) ? unblocked : cand;
    grant     = freeze ? '0 : (pool & (~pool + NUM_FU'(1)));
  end

  // Grant encoding and per-slot status decode
  always_comb begin
    grant_valid = |grant;
    grant_idx   = '0;
    busy        = '0;
    in_ex       = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      if (grant[k]) grant_idx = IDX_W'(k);
      busy[k]  = (state[k] != ST_EMPTY);
      in_ex[k] = (state[k] == ST_EX);
    end
  end

  // Per-slot next state; flush overrides everything, done+alloc reuses an EX slot back to back
  always_comb begin
    state_nxt = state;
    new_alloc = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (flush[i]) begin
        state_nxt[i] = ST_EMPTY;
      end else begin
        case (state[i])
          ST_EMPTY: begin
            if (alloc[i]) begin
              state_nxt[i] = ST_WAIT;
              new_alloc[i] = 1'b1;
            end
          end
          ST_WAIT: begin
            if (grant[i]) state_nxt[i] = ST_EX;
          end
          ST_EX: begin
            if (done[i]) begin
              state_nxt[i] = alloc[i] ? ST_WAIT : ST_EMPTY;
              new_alloc[i] = alloc[i];
            end
          end
          default: state_nxt[i] = ST_EMPTY;
        endcase
      end
    end
  end

  // Age update: released slots drop out of the order, new slots become youngest (lower index older among peers)
  always_comb begin
    older_nxt = older;
    for (int i = 0; i < NUM_FU; i++) begin
      for (int j = 0; j < NUM_FU; j++) begin
        if (i == j || state_nxt[i] == ST_EMPTY || state_nxt[j] == ST_EMPTY) begin
          older_nxt[i][j] = 1'b0;
        end else if (new_alloc[i] && new_alloc[j]) begin
          older_nxt[i][j] = (i < j);
        end else if (new_alloc[i]) begin
          older_nxt[i][j] = 1'b0;
        end else if (new_alloc[j]) begin
          older_nxt[i][j] = 1'b1;
        end
      end
    end
  end

  // State and age registers, cleared asynchronously
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= '0;
      older <= '0;
    end else begin
      state <= state_nxt;
      older <= older_nxt;
    end
  end

endmodule

// File: tb/tb_issue_age_sched.sv
// tb/tb_issue_age_sched.sv - self-checking bench for issue_age_sched
module tb_issue_age_sched;
  localparam int N = 5;
  localparam int S_EMPTY = 0;
  localparam int S_WAIT  = 1;
  localparam int S_EX    = 2;

  logic         CLK;
  logic         nRST;
  logic [N-1:0] alloc, rdy, done, flush;
  logic         freeze;
  logic [N-1:0] grant, busy, in_ex;
  logic         grant_valid;
  logic [2:0]   grant_idx;

  int n_assert = 0;
  int n_fail   = 0;

  issue_age_sched #(.NUM_FU(N), .IDX_W(3)) dut (
    .CLK(CLK), .nRST(nRST), .alloc(alloc), .rdy(rdy), .done(done), .flush(flush),
    .freeze(freeze), .grant(grant), .grant_valid(grant_valid), .grant_idx(grant_idx),
    .busy(busy), .in_ex(in_ex)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct packed {
    logic [N-1:0] a, r, d, f;
    logic         fz;
    logic [N-1:0] eg, eb, ex;
  } vec_t;
  vec_t vecs[$];

  function automatic void add(input logic [N-1:0] a, r, d, f, input logic fz,
                              input logic [N-1:0] eg, eb, ex);
    vec_t v;
    v.a = a; v.r = r; v.d = d; v.f = f; v.fz = fz; v.eg = eg; v.eb = eb; v.ex = ex;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_assert++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [N-1:0] eg, eb, ex);
    int eidx;
    eidx = 0;
    for (int k = 0; k < N; k++) if (eg[k]) eidx = k;
    check({tag, ".grant"},       int'(grant),       int'(eg));
    check({tag, ".grant_valid"}, int'(grant_valid), int'(|eg));
    check({tag, ".grant_idx"},   int'(grant_idx),   eidx);
    check({tag, ".busy"},        int'(busy),        int'(eb));
    check({tag, ".in_ex"},       int'(in_ex),       int'(ex));
  endtask

  task automatic drive(input logic [N-1:0] a, r, d, f, input logic fz);
    @(negedge CLK);
    alloc = a; rdy = r; done = d; flush = f; freeze = fz;
    #1;
  endtask

  // Reference model: slot states plus an oldest-first list of occupied slots
  int m_st[N];
  int m_q[$];

  function automatic void model_reset();
    for (int i = 0; i < N; i++) m_st[i] = S_EMPTY;
    m_q.delete();
  endfunction

  function automatic int model_grant();
    if (freeze) return -1;
    for (int k = 0; k < m_q.size(); k++) begin
      if (m_st[m_q[k]] == S_WAIT && rdy[m_q[k]] && !flush[m_q[k]]) return m_q[k];
    end
    return -1;
  endfunction

  function automatic void q_remove(input int s);
    for (int k = 0; k < m_q.size(); k++) begin
      if (m_q[k] == s) begin
        m_q.delete(k);
        return;
      end
    end
  endfunction

  function automatic void model_step(input int g);
    int fresh[$];
    for (int i = 0; i < N; i++) begin
      if (flush[i]) begin
        if (m_st[i] != S_EMPTY) q_remove(i);
        m_st[i] = S_EMPTY;
      end else if (m_st[i] == S_EMPTY && alloc[i]) begin
        m_st[i] = S_WAIT;
        fresh.push_back(i);
      end else if (m_st[i] == S_EX && done[i]) begin
        q_remove(i);
        if (alloc[i]) begin
          m_st[i] = S_WAIT;
          fresh.push_back(i);
        end else begin
          m_st[i] = S_EMPTY;
        end
      end else if (m_st[i] == S_WAIT && i == g) begin
        m_st[i] = S_EX;
      end
    end
    for (int k = 0; k < fresh.size(); k++) m_q.push_back(fresh[k]);
  endfunction

  function automatic logic [N-1:0] rbits(input int pct);
    logic [N-1:0] b;
    for (int k = 0; k < N; k++) b[k] = ($urandom_range(0, 99) < pct);
    return b;
  endfunction

  initial begin
    logic [N-1:0] eg, eb, ex;
    int g;
    nRST = 1'b0;
    alloc = '0; rdy = '0; done = '0; flush = '0; freeze = 1'b0;
    #2;
    check_outs("in_reset", '0, '0, '0);
    repeat (2) @(negedge CLK);
    nRST = 1'b1;

    //   alloc     rdy       done      flush   frz  grant     busy      in_ex
    add(5'b00000, 5'b00000, 5'b00000, 5'b00000, 0, 5'b00000, 5'b00000, 5'b00000);
    add(5'b00001, 5'b00001, 5'b00000, 5'b00000, 0, 5'b00000, 5'b00000, 5'b00000);
    add(5'b00000, 5'b00001, 5'b00000, 5'b00000, 0, 5'b00001, 5'b00001, 5'b00000);
    add(5'b00000, 5'b00000, 5'b00001, 5'b00000, 0, 5'b00000, 5'b00001, 5'b00001);
    add(5'b00000, 5'b00000, 5'b00000, 5'b00000, 0, 5'b00000, 5'b00000, 5'b00000);
    add(5'b01000, 5'b00000, 5'b00000, 5'b00000, 0, 5'b00000, 5'b00000, 5'b00000);
    add(5'b00010, 5'b00000, 5'b00000, 5'b00000, 0, 5'b00000, 5'b01000, 5'b00000);
    add(5'b00000, 5'b00000, 5'b00000, 5'b00000, 0, 5'b00000, 5'b01010, 5'b00000);
    add(5'b00000, 5'b01010, 5'b00000, 5'b00000, 0, 5'b01000, 5'b01010, 5'b00000);
    add(5'b00000, 5'b00000, 5'b01000, 5'b00000, 0, 5'b00000, 5'b01010, 5'b01000);
    add(5'b00000, 5'b00010, 5'b00000, 5'b00000, 0, 5'b00010, 5'b00010, 5'b00000);
    add(5'b00000, 5'b00000, 5'b00010, 5'b00000, 0, 5'b00000, 5'b00010, 5'b00010);
    add(5'b00000, 5'b00000, 5'b00000, 5'b00000, 0, 5'b00000, 5'b00000, 5'b00000);
    add(5'b10100, 5'b10100, 5'b00000, 5'b00000, 0, 5'b00000, 5'b00000, 5'b00000);
    add(5'b00000, 5'b10100, 5'b00000, 5'b00000, 0, 5'b00100, 5'b10100, 5'b00000);
    add(5'b00000, 5'b10100, 5'b00100, 5'b00000, 0, 5'b10000, 5'b10100, 5'b00100);
    add(5'b00000, 5'b00000, 5'b10000, 5'b00000, 0, 5'b00000, 5'b10000, 5'b10000);
    add(5'b00000, 5'b00000, 5'b00000, 5'b00000, 0, 5'b00000, 5'b00000, 5'b00000);
    add(5'b00001, 5'b00000, 5'b00000, 5'b00000, 0, 5'b00000, 5'b00000, 5'b00000);
    add(5'b00000, 5'b00001, 5'b00000, 5'b00000, 1, 5'b00000, 5'b00001, 5'b00000);
    add(5'b00000, 5'b00001, 5'b00000, 5'b00000, 1, 5'b00000, 5'b00001, 5'b00000);
    add(5'b00000, 5'b00001, 5'b00000, 5'b00000, 1, 5'b00000, 5'b00001, 5'b00000);
    add(5'b00000, 5'b00001, 5'b00000, 5'b00000, 0, 5'b00001, 5'b00001, 5'b00000);
    add(5'b00000, 5'b00000, 5'b00001, 5'b00000, 0, 5'b00000, 5'b00001, 5'b00001);
    add(5'b00000, 5'b00000, 5'b00000, 5'b00000, 0, 5'b00000, 5'b00000, 5'b00000);

    for (int v = 0; v < vecs.size(); v++) begin
      drive(vecs[v].a, vecs[v].r, vecs[v].d, vecs[v].f, vecs[v].fz);
      check_outs($sformatf("vec%0d", v), vecs[v].eg, vecs[v].eb, vecs[v].ex);
    end

    // Flush of the oldest ready slot hands the grant to the next candidate; re-alloc makes it youngest
    drive(5'b00010, 5'b00000, 5'b00000, 5'b00000, 0); check_outs("fl1", 5'b00000, 5'b00000, 5'b00000);
    drive(5'b00100, 5'b00000, 5'b00000, 5'b00000, 0); check_outs("fl2", 5'b00000, 5'b00010, 5'b00000);
    drive(5'b00001, 5'b00000, 5'b00000, 5'b00000, 0); check_outs("fl3", 5'b00000, 5'b00110, 5'b00000);
    drive(5'b00000, 5'b00011, 5'b00000, 5'b00010, 0); check_outs("fl4", 5'b00001, 5'b00111, 5'b00000);
    drive(5'b00010, 5'b00000, 5'b00001, 5'b00000, 0); check_outs("fl5", 5'b00000, 5'b00101, 5'b00001);
    drive(5'b00000, 5'b00110, 5'b00000, 5'b00000, 0); check_outs("fl6", 5'b00100, 5'b00110, 5'b00000);
    drive(5'b00000, 5'b00010, 5'b00100, 5'b00000, 0); check_outs("fl7", 5'b00010, 5'b00110, 5'b00100);
    drive(5'b00000, 5'b00000, 5'b00010, 5'b00000, 0); check_outs("fl8", 5'b00000, 5'b00010, 5'b00010);
    drive(5'b00000, 5'b00000, 5'b00000, 5'b00000, 0); check_outs("fl9", 5'b00000, 5'b00000, 5'b00000);

    // done+alloc on slot 0 while slot 4 waits: slot 0 reused as youngest, then async reset mid-flight
    drive(5'b00001, 5'b00000, 5'b00000, 5'b00000, 0); check_outs("da1", 5'b00000, 5'b00000, 5'b00000);
    drive(5'b00000, 5'b00001, 5'b00000, 5'b00000, 0); check_outs("da2", 5'b00001, 5'b00001, 5'b00000);
    drive(5'b10000, 5'b00000, 5'b00000, 5'b00000, 0); check_outs("da3", 5'b00000, 5'b00001, 5'b00001);
    drive(5'b00001, 5'b00000, 5'b00001, 5'b00000, 0); check_outs("da4", 5'b00000, 5'b10001, 5'b00001);
    drive(5'b00000, 5'b10001, 5'b00000, 5'b00000, 0); check_outs("da5", 5'b10000, 5'b10001, 5'b00000);
    drive(5'b00000, 5'b00001, 5'b00000, 5'b00000, 0); check_outs("da6", 5'b00001, 5'b10001, 5'b10000);
    nRST = 1'b0;
    #1;
    check_outs("async_rst", 5'b00000, 5'b00000, 5'b00000);
    @(negedge CLK);
    rdy = '0;
    nRST = 1'b1;
    model_reset();

    // Randomized traffic against the reference model
    for (int c = 0; c < 800; c++) begin
      drive(rbits(35), rbits(60), rbits(30), rbits(5), ($urandom_range(0, 99) < 15));
      g = model_grant();
      eg = '0; eb = '0; ex = '0;
      if (g >= 0) eg[g] = 1'b1;
      for (int i = 0; i < N; i++) begin
        eb[i] = (m_st[i] != S_EMPTY);
        ex[i] = (m_st[i] == S_EX);
      end
      check_outs($sformatf("rnd%0d", c), eg, eb, ex);
      model_step(g);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
